// File: rtl/bscant_pipe_serializer.sv
// Serializes one {words, N} indication message into N 32-bit beats (first beat one cycle after accept).
// Holds beats stable while the downstream ready is low; input accepted only when idle or on the last beat.
// Optional BSCANT_SER_HDR_EN prepends a {16'd0, N_sent} header beat.
module bscant_pipe_serializer #(
  parameter int MSG_WIDTH  = 144,
  parameter int LEN_WIDTH  = 16,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WORDS  = 4
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  pipe_enq_ena,
  input  logic [MSG_WIDTH-1:0]  pipe_enq_v,
  output logic                  pipe_enq_rdy,
  output logic                  out_enq_ena,
  output logic [DATA_WIDTH-1:0] out_enq_v,
  output logic                  out_last,
  input  logic                  out_enq_rdy,
  output logic                  err
);

  localparam int REM_W = $clog2(MAX_WORDS + 1) + 1;
`ifdef BSCANT_SER_HDR_EN
  localparam int BEATS = MAX_WORDS + 1;
`else
  localparam int BEATS = MAX_WORDS;
`endif
  localparam int SH_W = BEATS * DATA_WIDTH;

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state;
  logic [SH_W-1:0]   shift;
  logic [REM_W-1:0]  rem;
  logic              err_q;

  logic [LEN_WIDTH-1:0]                n_field;
  logic [MAX_WORDS*DATA_WIDTH-1:0]     words;
  logic                                trunc;
  logic [REM_W-1:0]                    n_sent;
  logic [SH_W-1:0]                     load_shift;
  logic [REM_W-1:0]                    load_rem;
  logic                                in_fire;
  logic                                out_fire;

  assign n_field = pipe_enq_v[LEN_WIDTH-1:0];
  assign words   = pipe_enq_v[MSG_WIDTH-1:LEN_WIDTH];
  assign trunc   = n_field > LEN_WIDTH'(MAX_WORDS);
  assign n_sent  = trunc ? REM_W'(MAX_WORDS) : n_field[REM_W-1:0];

`ifdef BSCANT_SER_HDR_EN
  assign load_shift = {words, DATA_WIDTH'(n_sent)};
  assign load_rem   = n_sent + REM_W'(1);
`else
  assign load_shift = words;
  assign load_rem   = n_sent;
`endif

  assign out_enq_ena  = (state == SEND);
  assign out_enq_v    = (state == SEND) ? shift[DATA_WIDTH-1:0] : '0;
  assign out_last     = (state == SEND) && (rem == REM_W'(1));
  assign err          = err_q;
  // Same-cycle reload when the final beat is leaving keeps back-to-back messages gapless.
  assign pipe_enq_rdy = nRST && ((state == IDLE) || (out_last && out_enq_rdy));
  assign in_fire      = pipe_enq_ena && pipe_enq_rdy;
  assign out_fire     = (state == SEND) && out_enq_rdy;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      shift <= '0;
      rem   <= '0;
      err_q <= 1'b0;
    end else if (in_fire) begin
      shift <= load_shift;
      rem   <= load_rem;
      err_q <= err_q | trunc;
      state <= (n_field == '0) ? IDLE : SEND;
    end else if (out_fire) begin
      shift <= shift >> DATA_WIDTH;
      rem   <= rem - REM_W'(1);
      if (rem == REM_W'(1))
        state <= IDLE;
    end
  end

endmodule

// File: tb/tb_bscant_pipe_serializer.sv
// Directed bench for bscant_pipe_serializer: latency, back-to-back, backpressure, N=0/N>MAX, reset abort.
module tb_bscant_pipe_serializer;

  logic         CLK = 1'b0;
  logic         nRST;
  logic         in_ena;
  logic [143:0] in_msg;
  logic         in_rdy;
  logic         o_ena;
  logic [31:0]  o_v;
  logic         o_last;
  logic         o_rdy;
  logic         err;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  bscant_pipe_serializer dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .pipe_enq_ena (in_ena),
    .pipe_enq_v   (in_msg),
    .pipe_enq_rdy (in_rdy),
    .out_enq_ena  (o_ena),
    .out_enq_v    (o_v),
    .out_last     (o_last),
    .out_enq_rdy  (o_rdy),
    .err          (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Checks one accepted beat in the current cycle, then advances a cycle.
  task automatic beat(input string tag, input logic [31:0] v, input logic l);
    chk({tag, ".ena"}, 32'(o_ena), 32'd1);
    chk({tag, ".v"}, o_v, v);
    chk({tag, ".last"}, 32'(o_last), 32'(l));
    step();
  endtask

  task automatic hdr(input string tag, input logic [31:0] n);
`ifdef BSCANT_SER_HDR_EN
    beat({tag, ".hdr"}, n, 1'b0);
`else
    if (n == 32'hFFFF_FFFF) chk({tag, ".hdr"}, 32'(o_ena), 32'd0);
`endif
  endtask

  logic [143:0] msg1, msg2, msg0, msg7;

  initial begin
    msg1 = {64'd0, 32'hDEADBEEF, 16'd0, 16'd5, 16'd2};
    msg2 = {32'h66664444, 32'h55552222, 32'h33331111, 32'h00020005, 16'd4};
    msg0 = {32'hAAAA0001, 32'hAAAA0002, 32'hAAAA0003, 32'hAAAA0004, 16'd0};
    msg7 = {32'h0D0D0D0D, 32'h0C0C0C0C, 32'h0B0B0B0B, 32'h0A0A0A0A, 16'd7};

    nRST = 1'b0; in_ena = 1'b0; in_msg = '0; o_rdy = 1'b1;
    #1;
    chk("rst.ena",  32'(o_ena),  32'd0);
    chk("rst.v",    o_v,         32'd0);
    chk("rst.last", 32'(o_last), 32'd0);
    chk("rst.err",  32'(err),    32'd0);
    chk("rst.rdy",  32'(in_rdy), 32'd0);
    step(); step();
    nRST = 1'b1;
    step();
    chk("idle.rdy", 32'(in_rdy), 32'd1);
    chk("idle.ena", 32'(o_ena),  32'd0);

    // Test 1: N=2, first beat the cycle after accept
    in_ena = 1'b1; in_msg = msg1;
    step();
    in_ena = 1'b0;
    hdr("t1", 32'd2);
    beat("t1.b0", 32'h00000005, 1'b0);
    chk("t1.rdy_on_last", 32'(in_rdy), 32'd1);
    beat("t1.b1", 32'hDEADBEEF, 1'b1);
    chk("t1.done", 32'(o_ena), 32'd0);

    // Test 2: N=4, second message loaded on the last beat
    in_ena = 1'b1; in_msg = msg2;
    step();
    hdr("t2a", 32'd4);
    chk("t2.rdy_busy", 32'(in_rdy), 32'd0);
    beat("t2a.b0", 32'h00020005, 1'b0);
    beat("t2a.b1", 32'h33331111, 1'b0);
    beat("t2a.b2", 32'h55552222, 1'b0);
    chk("t2.rdy_last", 32'(in_rdy), 32'd1);
    beat("t2a.b3", 32'h66664444, 1'b1);
    in_ena = 1'b0;
    hdr("t2b", 32'd4);
    beat("t2b.b0", 32'h00020005, 1'b0);

    // Test 3: backpressure on beat 2 for 3 cycles
    o_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t3.hold.ena", 32'(o_ena), 32'd1);
      chk("t3.hold.v", o_v, 32'h33331111);
      chk("t3.hold.last", 32'(o_last), 32'd0);
      step();
    end
    o_rdy = 1'b1;
    beat("t3.b1", 32'h33331111, 1'b0);
    beat("t3.b2", 32'h55552222, 1'b0);
    beat("t3.b3", 32'h66664444, 1'b1);
    chk("t3.done", 32'(o_ena), 32'd0);
    chk("t3.err", 32'(err), 32'd0);

    // Test 4: N=0 consumed silently, N=7 truncated with sticky err
    in_ena = 1'b1; in_msg = msg0;
    step();
    in_ena = 1'b0;
    chk("t4.n0.ena", 32'(o_ena), 32'd0);
    chk("t4.n0.rdy", 32'(in_rdy), 32'd1);
    step();
    chk("t4.n0.ena2", 32'(o_ena), 32'd0);
    chk("t4.n0.err", 32'(err), 32'd0);
    in_ena = 1'b1; in_msg = msg7;
    step();
    in_ena = 1'b0;
    chk("t4.n7.err", 32'(err), 32'd1);
    hdr("t4.n7", 32'd4);
    beat("t4.n7.b0", 32'h0A0A0A0A, 1'b0);
    beat("t4.n7.b1", 32'h0B0B0B0B, 1'b0);
    beat("t4.n7.b2", 32'h0C0C0C0C, 1'b0);
    beat("t4.n7.b3", 32'h0D0D0D0D, 1'b1);
    chk("t4.n7.done", 32'(o_ena), 32'd0);
    step();
    chk("t4.err_sticky", 32'(err), 32'd1);

    // Test 5: reset mid-message aborts it
    in_ena = 1'b1; in_msg = msg2;
    step();
    in_ena = 1'b0;
    hdr("t5", 32'd4);
    beat("t5.b0", 32'h00020005, 1'b0);
    nRST = 1'b0;
    #1;
    chk("t5.rst.ena",  32'(o_ena),  32'd0);
    chk("t5.rst.v",    o_v,         32'd0);
    chk("t5.rst.last", 32'(o_last), 32'd0);
    chk("t5.rst.err",  32'(err),    32'd0);
    chk("t5.rst.rdy",  32'(in_rdy), 32'd0);
    step();
    nRST = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5.post.ena", 32'(o_ena), 32'd0);
      chk("t5.post.rdy", 32'(in_rdy), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
